// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the ARM pipeline control blocks.
// SRAM wait FSM states, register index width default, NOP encoding.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } sram_state_e;

  localparam int REG_W_DEF = 4;

  // mov r0, r0 : what a bubble in ID/EX decodes as
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall control bundle between the pipeline and the controller.
// master = pipeline side, slave = hazard_stall_controller.
interface hazard_stall_controller_if
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 16
);

  logic             forward_en;
  logic             id_valid;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             two_src;
  logic [REG_W-1:0] Dest_EXE;
  logic             WB_EN_EXE;
  logic             MEM_R_EN_EXE;
  logic [REG_W-1:0] Dest_MEM;
  logic             WB_EN_MEM;
  logic             MEM_R_EN_MEM;
  logic             MEM_W_EN_MEM;
  logic             sram_ready;
  logic             branch_taken;
  logic             cnt_clr;

  logic             forward_hazard;
  logic             freeze_pc;
  logic             freeze_ifid;
  logic             bubble_idex;
  logic             flush;
  logic             freeze_all;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] wait_cnt;

  modport slave (
    input  forward_en, id_valid, src1, src2, two_src,
    input  Dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
    input  Dest_MEM, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM,
    input  sram_ready, branch_taken, cnt_clr,
    output forward_hazard, freeze_pc, freeze_ifid,
    output bubble_idex, flush, freeze_all, mem_timeout,
    output stall_cnt, wait_cnt
  );

  modport master (
    output forward_en, id_valid, src1, src2, two_src,
    output Dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
    output Dest_MEM, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM,
    output sram_ready, branch_taken, cnt_clr,
    input  forward_hazard, freeze_pc, freeze_ifid,
    input  bubble_idex, flush, freeze_all, mem_timeout,
    input  stall_cnt, wait_cnt
  );

endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && !(&q))
      q <= q + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/bubble/flush/freeze sequencing for the five-stage ARM pipeline.
// Also tracks SRAM waits with a sticky timeout and two perf counters.
module hazard_stall_controller
  import arm_pipe_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input logic clk,
  input logic rst_n,
  hazard_stall_controller_if.slave bus
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 2);

  sram_state_e      state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;

  logic [REG_W-1:0] s1, s2, de, dm;
  logic             m_exe, m_mem, raw;
  logic             acc, frz, stall_hit;
  logic             inc_stall, inc_wait;
  logic [CNT_W-1:0] stall_q, wait_q;

  assign s1 = bus.src1;
  assign s2 = bus.src2;
  assign de = bus.Dest_EXE;
  assign dm = bus.Dest_MEM;

  assign m_exe = bus.id_valid &
    ((de == s1) | (bus.two_src & (de == s2)));
  assign m_mem = bus.id_valid &
    ((dm == s1) | (bus.two_src & (dm == s2)));

  // with forwarding only a load in EXE cannot be bypassed
  assign raw = bus.forward_en
    ? (bus.MEM_R_EN_EXE & m_exe)
    : ((bus.WB_EN_EXE & m_exe) | (bus.WB_EN_MEM & m_mem));

  assign acc = bus.MEM_R_EN_MEM | bus.MEM_W_EN_MEM;
  assign frz = rst_n & acc & !bus.sram_ready & (state_q != ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      RUN: begin
        if (acc && !bus.sram_ready) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        if (bus.sram_ready || !acc)
          state_d = RUN;
        else if (wcnt_q == WC_LAST)
          state_d = ERR;
        else
          wcnt_d = wcnt_q + WC_W'(1);
      end
      ERR: state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    bus.flush       = 1'b0;
    bus.bubble_idex = 1'b0;
    bus.freeze_pc   = 1'b0;
    bus.freeze_ifid = 1'b0;
    stall_hit       = 1'b0;
    if (rst_n && !frz) begin
      if (bus.branch_taken) begin
        bus.flush       = 1'b1;
        bus.bubble_idex = 1'b1;
      end else if (raw) begin
        bus.freeze_pc   = 1'b1;
        bus.freeze_ifid = 1'b1;
        bus.bubble_idex = 1'b1;
        stall_hit       = 1'b1;
      end
    end
  end

  assign bus.forward_hazard = rst_n & bus.forward_en;
  assign bus.freeze_all     = frz;
  assign bus.mem_timeout    = rst_n & (state_q == ERR);

  assign inc_stall = stall_hit;
  assign inc_wait  = frz;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_stall),
    .clr   (bus.cnt_clr),
    .q     (stall_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_wait),
    .clr   (bus.cnt_clr),
    .q     (wait_q)
  );

  assign bus.stall_cnt = stall_q;
  assign bus.wait_cnt  = wait_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: randomized and directed
// stimulus, expected outputs from a cycle-level behavioural model.
module tb_hazard_stall_controller;

  localparam int RW   = 4;
  localparam int CW   = 8;
  localparam int TMO  = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic          rst;
    logic          fwd;
    logic          idv;
    logic [RW-1:0] s1;
    logic [RW-1:0] s2;
    logic          two;
    logic [RW-1:0] de;
    logic          wbe;
    logic          mre;
    logic [RW-1:0] dm;
    logic          wbm;
    logic          mrm;
    logic          mwm;
    logic          rdy;
    logic          br;
    logic          clr;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [22:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  hazard_stall_controller_if #(.REG_W(RW), .CNT_W(CW)) bus ();

  hazard_stall_controller #(
    .REG_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // model state: what the registers hold after the most recent edge
  int m_stall = 0;
  int m_wait  = 0;
  int m_run   = 0;
  bit m_err   = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, rdy: 1'b1, default: '0};
    return s;
  endfunction

  function automatic bit uses(stim_t s, logic [RW-1:0] r);
    return s.idv && (r == s.s1 || (s.two && r == s.s2));
  endfunction

  task automatic apply(stim_t s);
    bit acc, fz, raw, st, fl;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = s.rst;
    bus.forward_en   = s.fwd;
    bus.id_valid     = s.idv;
    bus.src1         = s.s1;
    bus.src2         = s.s2;
    bus.two_src      = s.two;
    bus.Dest_EXE     = s.de;
    bus.WB_EN_EXE    = s.wbe;
    bus.MEM_R_EN_EXE = s.mre;
    bus.Dest_MEM     = s.dm;
    bus.WB_EN_MEM    = s.wbm;
    bus.MEM_R_EN_MEM = s.mrm;
    bus.MEM_W_EN_MEM = s.mwm;
    bus.sram_ready   = s.rdy;
    bus.branch_taken = s.br;
    bus.cnt_clr      = s.clr;
    cyc++;
    if (!s.rst) begin
      m_stall = 0; m_wait = 0; m_run = 0; m_err = 0;
      e.cyc = cyc; e.v = '0;
      q.push_back(e);
      return;
    end
    acc = s.mrm || s.mwm;
    fz  = acc && !s.rdy && !m_err;
    if (s.fwd)
      raw = s.mre && uses(s, s.de);
    else
      raw = (s.wbe && uses(s, s.de)) || (s.wbm && uses(s, s.dm));
    fl = !fz && s.br;
    st = !fz && !s.br && raw;
    e.cyc = cyc;
    e.v = {s.fwd, st, st, st || fl, fl, fz, m_err,
           CW'(m_stall), CW'(m_wait)};
    q.push_back(e);
    if (s.clr) begin
      m_stall = 0; m_wait = 0;
    end else begin
      if (st) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (fz) m_wait  = (m_wait  < CMAX) ? m_wait  + 1 : CMAX;
    end
    // a run of TMO consecutive frozen cycles trips the sticky error
    if (fz) begin
      m_run++;
      if (m_run == TMO) m_err = 1;
    end else begin
      m_run = 0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [22:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {bus.forward_hazard, bus.freeze_pc, bus.freeze_ifid,
             bus.bubble_idex, bus.flush, bus.freeze_all,
             bus.mem_timeout, bus.stall_cnt, bus.wait_cnt};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h", e.cyc, got, e.v);
      end
    end
  end

  initial begin
    stim_t s;
    int busy;
    rst_n = 1'b0;
    s = idle();
    s.rst = 1'b0;
    repeat (3) apply(s);

    // load-use with forwarding
    s = idle(); s.fwd = 1; s.mre = 1; s.wbe = 1; s.de = 3;
    s.idv = 1; s.s1 = 3;
    apply(s);
    apply(idle());

    // MEM-stage producer without forwarding, src2 read or not
    s = idle(); s.wbm = 1; s.dm = 5; s.idv = 1; s.two = 1; s.s2 = 5;
    s.s1 = 1;
    apply(s);
    s.two = 0;
    apply(s);

    // four-cycle SRAM wait with a pending branch
    s = idle(); s.mrm = 1; s.rdy = 0; s.br = 1;
    repeat (4) apply(s);
    s.rdy = 1;
    apply(s);

    // branch beats a raw stall
    s = idle(); s.br = 1; s.wbe = 1; s.de = 2; s.idv = 1; s.s1 = 2;
    apply(s);

    // timeout, sticky, then reset recovery
    s = idle(); s.mwm = 1; s.rdy = 0; s.wbe = 1; s.de = 6;
    s.idv = 1; s.s1 = 6;
    repeat (TMO + 4) apply(s);
    s.rst = 0;
    apply(s);
    apply(idle());

    // saturate stall counter, then clear during a stall
    s = idle(); s.wbe = 1; s.de = 7; s.idv = 1; s.s1 = 7;
    repeat (CMAX + 5) apply(s);
    s.clr = 1;
    apply(s);
    s.clr = 0;
    repeat (2) apply(s);

    busy = 0;
    repeat (3000) begin
      s = idle();
      s.rst = ($urandom_range(0, 149) != 0);
      s.fwd = $urandom_range(0, 1);
      s.idv = ($urandom_range(0, 4) != 0);
      s.s1  = RW'($urandom_range(0, 3));
      s.s2  = RW'($urandom_range(0, 3));
      s.two = $urandom_range(0, 1);
      s.de  = RW'($urandom_range(0, 3));
      s.wbe = $urandom_range(0, 1);
      s.mre = s.wbe && ($urandom_range(0, 2) == 0);
      s.dm  = RW'($urandom_range(0, 3));
      s.wbm = $urandom_range(0, 1);
      s.mrm = ($urandom_range(0, 3) == 0);
      s.mwm = ($urandom_range(0, 5) == 0);
      s.br  = ($urandom_range(0, 7) == 0);
      s.clr = ($urandom_range(0, 99) == 0);
      if (busy > 0) begin
        s.rdy = 0;
        s.mrm = 1;
        busy--;
      end else begin
        s.rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) busy = $urandom_range(1, 12);
      end
      apply(s);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
